// File: rtl/scan_doubler.sv
// -----------------------------------------------------------------------------
// scan_doubler
//   Line-doubling scan converter. Each source line is captured into one half of
//   a ping-pong line buffer while the other half is replayed twice at the
//   doubled pixel rate. The output horizontal sync is regenerated from the
//   read pointer. The vertical sync is carried with each line.
//
//   The ce_in that carries the hs_in falling edge is the last pixel of the line
//   being closed. That pixel is stored into the outgoing buffer. The buffers
//   then swap, so the next ce_in writes entry 0 of the fresh buffer. As a
//   result, a ce_in write and a ce_out read never touch the same half.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   ce_in     source pixel strobe (one clk wide)
//   ce_out    output pixel strobe, twice the ce_in rate, aligned with ce_in
//   hs_in     source horizontal sync, active-low
//   vs_in     source vertical sync, active-low
//   blank_in  source blank, active-high
//   rgb_in    source colour {BLUE,GREEN,RED,RBG2}
//   vga_hs    doubled-rate horizontal sync, active-low
//   vga_vs    vertical sync, active-low, changes only at output line 1 start
//   vga_rgb   doubled-rate colour, forced to 0 while blanked or idle
//
// Handshake: there is no back-pressure. ce_in and ce_out are free-running
// qualifiers. Every strobe is consumed on the clk edge where it is high.
// -----------------------------------------------------------------------------
module scan_doubler #(
   parameter int LINE_MAX = 512,
   parameter int HS_W     = 48
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce_in,
   input  logic       ce_out,
   input  logic       hs_in,
   input  logic       vs_in,
   input  logic       blank_in,
   input  logic [3:0] rgb_in,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic [3:0] vga_rgb
);

   localparam int AW = $clog2(LINE_MAX);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW-1:0] PTR_LAST = AW'(LINE_MAX - 1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(LINE_MAX);
   localparam logic [31:0]   HS_W_U   = 32'(HS_W);

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_LINE1,
      RD_LINE2
   } rd_state_t;

   // Both halves of the ping-pong buffer live in one array.
   // The address MSB selects the half.
   logic [4:0]    mem [0:2*LINE_MAX-1];

   logic          sel;         // half currently being written
   logic          hs_prev;     // hs_in as seen on the previous ce_in
   logic          line_valid;  // a line start has been seen since reset
   logic          vs_line;
   logic          line_start;
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW-1:0] rp_next;
   logic [AW:0]   cnt;         // pixels written this line, saturates at LINE_MAX
   logic [AW:0]   len;
   logic [AW:0]   len_next;
   logic          rp_last;
   rd_state_t     state;
   rd_state_t     state_next;
   logic [4:0]    rd_q;
   logic          out_act;
   logic          hs_q;
   logic          vs_q;

   assign line_start = ce_in && hs_prev && !hs_in;
   // The closing pixel is counted here. The count is clamped to the buffer depth.
   assign len_next   = (cnt == CNT_FULL) ? CNT_FULL : cnt + CNT_ONE;
   assign rp_last    = ({1'b0, rp} == len - CNT_ONE);

   // ---------------- write side ----------------
   always_ff @(posedge clk) begin
      if (ce_in) begin
         mem[{sel, wp}] <= {blank_in, rgb_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel        <= 1'b0;
         hs_prev    <= 1'b1;
         line_valid <= 1'b0;
         vs_line    <= 1'b0;
         wp         <= '0;
         cnt        <= '0;
         len        <= '0;
      end else if (ce_in) begin
         hs_prev <= hs_in;
         if (line_start) begin
            sel        <= ~sel;
            wp         <= '0;
            cnt        <= '0;
            line_valid <= 1'b1;
            // The first start after reset closes a partial line, so the
            // length stays unmeasured until the next start.
            len        <= line_valid ? len_next : '0;
            vs_line    <= vs_in;
         end else begin
            // Once the pointer reaches the last entry it stays there, and any
            // extra pixels overwrite that entry.
            if (wp != PTR_LAST) wp <= wp + PTR_ONE;
            if (cnt != CNT_FULL) cnt <= cnt + CNT_ONE;
         end
      end
   end

   // ---------------- read side FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RD_IDLE;
         rp    <= '0;
      end else begin
         state <= state_next;
         rp    <= rp_next;
      end
   end

   always_comb begin
      state_next = state;
      rp_next    = rp;
      if (line_start) begin
         // A new line preempts whatever is being replayed.
         rp_next    = '0;
         state_next = line_valid ? RD_LINE1 : RD_IDLE;
      end else if (ce_out && state != RD_IDLE) begin
         if (rp_last) begin
            rp_next    = '0;
            state_next = (state == RD_LINE1) ? RD_LINE2 : RD_IDLE;
         end else begin
            rp_next = rp + PTR_ONE;
         end
      end
   end

   // ---------------- output stage ----------------
   always_ff @(posedge clk) begin
      if (ce_out) begin
         rd_q <= mem[{~sel, rp}];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_act <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
      end else if (ce_out) begin
         out_act <= (state != RD_IDLE);
         hs_q    <= (state == RD_IDLE) || (32'(rp) >= HS_W_U);
         if (state == RD_LINE1 && rp == '0) vs_q <= vs_line;
      end
   end

   assign vga_rgb = (out_act && !rd_q[4]) ? rd_q[3:0] : 4'h0;
   assign vga_hs  = hs_q;
   assign vga_vs  = vs_q;

endmodule

// File: tb/tb_scan_doubler.sv
// -----------------------------------------------------------------------------
// tb_scan_doubler
//   Directed bench for scan_doubler. Each source pixel occupies four clks,
//   with ce_in on the first clk and ce_out on the first and third. After each
//   ce_out edge, the outputs are logged into queues. Each line driver records
//   the log index of the line-start sample, and each scenario checks its
//   windows against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_scan_doubler;

   localparam int LINE_MAX = 512;
   localparam int HS_W     = 48;

   logic       clk = 1'b0;
   logic       rst;
   logic       ce_in;
   logic       ce_out;
   logic       hs_in;
   logic       vs_in;
   logic       blank_in;
   logic [3:0] rgb_in;
   logic       vga_hs;
   logic       vga_vs;
   logic [3:0] vga_rgb;

   int checks = 0;
   int errors = 0;

   logic [3:0] rgb_log[$];
   logic       hs_log[$];
   logic       vs_log[$];
   int         ls_idx[$];

   always #5 clk = ~clk;

   scan_doubler #(
      .LINE_MAX (LINE_MAX),
      .HS_W     (HS_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ce_in    (ce_in),
      .ce_out   (ce_out),
      .hs_in    (hs_in),
      .vs_in    (vs_in),
      .blank_in (blank_in),
      .rgb_in   (rgb_in),
      .vga_hs   (vga_hs),
      .vga_vs   (vga_vs),
      .vga_rgb  (vga_rgb)
   );

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      rgb_log.delete();
      hs_log.delete();
      vs_log.delete();
      ls_idx.delete();
   endtask

   task automatic log_sample();
      rgb_log.push_back(vga_rgb);
      hs_log.push_back(vga_hs);
      vs_log.push_back(vga_vs);
   endtask

   task automatic do_reset();
      ce_in = 1'b0; ce_out = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
      blank_in = 1'b0; rgb_in = 4'h0; rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic drive_pixel(input logic b, input logic [3:0] c, input logic hs, input logic vs);
      blank_in = b; rgb_in = c; hs_in = hs; vs_in = vs;
      ce_in = 1'b1; ce_out = 1'b1;
      @(posedge clk); #1;
      log_sample();
      ce_in = 1'b0; ce_out = 1'b0;
      @(posedge clk); #1;
      ce_out = 1'b1;
      @(posedge clk); #1;
      log_sample();
      ce_out = 1'b0;
      @(posedge clk); #1;
   endtask

   // mode 0: colour = pixel index, mode 1: inverted index, else constant c
   function automatic logic [3:0] pix_rgb(input int mode, input int p, input logic [3:0] c);
      logic [3:0] v;
      v = 4'(p);
      if (mode == 0) return v;
      if (mode == 1) return ~v;
      return c;
   endfunction

   // Drives pixels p0..p1-1 of an n-pixel line. Pixel n-1 carries the hs
   // falling edge that closes the line.
   task automatic drive_line(input int p0, input int p1, input int n, input logic b,
                             input int mode, input logic [3:0] c, input logic vs);
      for (int p = p0; p < p1; p++) begin
         if (p == n - 1) ls_idx.push_back(rgb_log.size());
         drive_pixel(b, pix_rgb(mode, p, c), (p == n - 1) ? 1'b0 : 1'b1, vs);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      ce_in = 1'b0; ce_out = 1'b0; hs_in = 1'b1; vs_in = 1'b0;
      blank_in = 1'b0; rgb_in = 4'hA; rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (vga_rgb !== 4'h0) begin errors++; $display("FAIL reset_rgb: got %h want 0", vga_rgb); end
      checks++;
      if (vga_hs !== 1'b1) begin errors++; $display("FAIL reset_hs: got %b want 1", vga_hs); end
      checks++;
      if (vga_vs !== 1'b1) begin errors++; $display("FAIL reset_vs: got %b want 1", vga_vs); end
      rst = 1'b0;
   endtask

   task automatic test_steady();
      int s1, bad, first;
      logic [3:0] exp;
      logic exp_hs;
      do_reset();
      drive_line(0, 10, 10, 1'b0, 0, 4'h0, 1'b1);
      drive_line(0, 384, 384, 1'b0, 0, 4'h0, 1'b1);
      drive_line(0, 384, 384, 1'b0, 0, 4'h0, 1'b1);
      s1 = ls_idx[1];
      bad = 0; first = -1;
      for (int i = 0; i <= s1; i++) begin
         if (rgb_log[i] !== 4'h0 || hs_log[i] !== 1'b1 || vs_log[i] !== 1'b1) begin
            bad++; if (first < 0) first = i;
         end
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL steady_idle: got %0d bad samples (first %0d) want 0", bad, first); end
      checks++;
      if (rgb_log[s1+1] !== 4'h0) begin errors++; $display("FAIL steady_first: got %h want 0", rgb_log[s1+1]); end
      checks++;
      if (rgb_log[s1+2] !== 4'h1) begin errors++; $display("FAIL steady_second: got %h want 1", rgb_log[s1+2]); end
      bad = 0; first = -1;
      for (int j = 0; j < 768; j++) begin
         exp    = 4'(j % 384);
         exp_hs = ((j % 384) >= HS_W);
         if (rgb_log[s1+1+j] !== exp || hs_log[s1+1+j] !== exp_hs || vs_log[s1+1+j] !== 1'b1) begin
            bad++; if (first < 0) first = j;
         end
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL steady_seq: got %0d bad samples (first offset %0d) want 0", bad, first); end
   endtask

   task automatic test_sync();
      int s1, s2, s10, vs_low, hs_low;
      do_reset();
      drive_line(0, 10, 10, 1'b0, 0, 4'h0, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         drive_line(0, 100, 100, 1'b0, 0, 4'h0, (k >= 2 && k <= 9) ? 1'b0 : 1'b1);
      end
      s1 = ls_idx[1]; s2 = ls_idx[2]; s10 = ls_idx[10];
      vs_low = 0; hs_low = 0;
      for (int i = s1 + 1; i <= s10; i++) begin
         if (vs_log[i] === 1'b0) vs_low++;
         if (hs_log[i] === 1'b0) hs_low++;
      end
      checks++;
      if (vs_low !== 1600) begin errors++; $display("FAIL sync_vs_count: got %0d low samples want 1600", vs_low); end
      checks++;
      if (hs_low !== 864) begin errors++; $display("FAIL sync_hs_count: got %0d low samples want 864", hs_low); end
      checks++;
      if (vs_log[s2] !== 1'b1) begin errors++; $display("FAIL sync_vs_before: got %b want 1", vs_log[s2]); end
      checks++;
      if (vs_log[s2+1] !== 1'b0) begin errors++; $display("FAIL sync_vs_fall: got %b want 0", vs_log[s2+1]); end
      checks++;
      if (vs_log[s10] !== 1'b0) begin errors++; $display("FAIL sync_vs_last: got %b want 0", vs_log[s10]); end
      checks++;
      if (vs_log[s10+1] !== 1'b1) begin errors++; $display("FAIL sync_vs_rise: got %b want 1", vs_log[s10+1]); end
   endtask

   task automatic test_overflow();
      int s1, bad, first, p;
      logic [3:0] exp;
      do_reset();
      drive_line(0, 10, 10, 1'b0, 0, 4'h0, 1'b1);
      drive_line(0, 600, 600, 1'b0, 0, 4'h0, 1'b1);
      drive_line(0, 600, 600, 1'b0, 0, 4'h0, 1'b1);
      s1 = ls_idx[1];
      checks++;
      if (rgb_log[s1+512] !== 4'h7) begin errors++; $display("FAIL ovf_last_entry: got %h want 7", rgb_log[s1+512]); end
      bad = 0; first = -1;
      for (int j = 0; j < 1024; j++) begin
         p   = j % 512;
         exp = (p == 511) ? 4'h7 : 4'(p);
         if (rgb_log[s1+1+j] !== exp) begin bad++; if (first < 0) first = j; end
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL ovf_seq: got %0d bad samples (first offset %0d) want 0", bad, first); end
      bad = 0; first = -1;
      for (int i = s1 + 1025; i <= s1 + 1200; i++) begin
         if (rgb_log[i] !== 4'h0 || hs_log[i] !== 1'b1) begin bad++; if (first < 0) first = i; end
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL ovf_idle: got %0d bad samples (first %0d) want 0", bad, first); end
   endtask

   task automatic test_early();
      int s1, s2, bad, first, p;
      logic [3:0] exp;
      logic exp_hs;
      do_reset();
      drive_line(0, 10, 10, 1'b0, 0, 4'h0, 1'b1);
      drive_line(0, 384, 384, 1'b0, 0, 4'h0, 1'b1);
      drive_line(0, 300, 300, 1'b0, 1, 4'h0, 1'b1);
      drive_line(0, 300, 300, 1'b0, 0, 4'h0, 1'b1);
      s1 = ls_idx[1]; s2 = ls_idx[2];
      checks++;
      if (rgb_log[s2] !== 4'h7) begin errors++; $display("FAIL early_cut: got %h want 7", rgb_log[s2]); end
      checks++;
      if (hs_log[s2] !== 1'b1) begin errors++; $display("FAIL early_cut_hs: got %b want 1", hs_log[s2]); end
      checks++;
      if (rgb_log[s2+1] !== 4'hF) begin errors++; $display("FAIL early_restart: got %h want f", rgb_log[s2+1]); end
      checks++;
      if (hs_log[s2+1] !== 1'b0) begin errors++; $display("FAIL early_restart_hs: got %b want 0", hs_log[s2+1]); end
      bad = 0; first = -1;
      for (int j = 0; j < 600; j++) begin
         p = (j < 384) ? j : j - 384;
         exp_hs = (p >= HS_W);
         if (rgb_log[s1+1+j] !== 4'(p) || hs_log[s1+1+j] !== exp_hs) begin bad++; if (first < 0) first = j; end
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL early_old_seq: got %0d bad samples (first offset %0d) want 0", bad, first); end
      bad = 0; first = -1;
      for (int j = 0; j < 600; j++) begin
         p      = j % 300;
         exp    = ~4'(p);
         exp_hs = (p >= HS_W);
         if (rgb_log[s2+1+j] !== exp || hs_log[s2+1+j] !== exp_hs) begin bad++; if (first < 0) first = j; end
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL early_new_seq: got %0d bad samples (first offset %0d) want 0", bad, first); end
   endtask

   task automatic test_blank();
      int s1, s2, bad, hs_low;
      do_reset();
      drive_line(0, 10, 10, 1'b0, 0, 4'h0, 1'b1);
      drive_line(0, 100, 100, 1'b1, 2, 4'hF, 1'b1);
      drive_line(0, 100, 100, 1'b0, 2, 4'h5, 1'b1);
      drive_line(0, 10, 10, 1'b0, 2, 4'h0, 1'b1);
      s1 = ls_idx[1]; s2 = ls_idx[2];
      bad = 0; hs_low = 0;
      for (int i = s1 + 1; i <= s1 + 200; i++) begin
         if (rgb_log[i] !== 4'h0) bad++;
         if (hs_log[i] === 1'b0) hs_low++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL blank_rgb: got %0d nonzero samples want 0", bad); end
      checks++;
      if (hs_low !== 96) begin errors++; $display("FAIL blank_hs: got %0d low samples want 96", hs_low); end
      bad = 0;
      for (int i = s2 + 1; i <= s2 + 20; i++) begin
         if (rgb_log[i] !== 4'h5) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL blank_after: got %0d bad samples want 0", bad); end
   endtask

   task automatic test_reset_mid();
      int r2, bad, first;
      do_reset();
      drive_line(0, 10, 10, 1'b0, 0, 4'h0, 1'b0);
      drive_line(0, 200, 200, 1'b0, 0, 4'h0, 1'b0);
      drive_line(0, 100, 200, 1'b0, 0, 4'h0, 1'b0);
      checks++;
      if (vga_vs !== 1'b0) begin errors++; $display("FAIL rstmid_pre_vs: got %b want 0", vga_vs); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (vga_rgb !== 4'h0) begin errors++; $display("FAIL rstmid_rgb: got %h want 0", vga_rgb); end
      checks++;
      if (vga_hs !== 1'b1) begin errors++; $display("FAIL rstmid_hs: got %b want 1", vga_hs); end
      checks++;
      if (vga_vs !== 1'b1) begin errors++; $display("FAIL rstmid_vs: got %b want 1", vga_vs); end
      clear_logs();
      drive_line(100, 200, 200, 1'b0, 0, 4'h0, 1'b0);
      drive_line(0, 200, 200, 1'b0, 1, 4'h0, 1'b1);
      drive_line(0, 20, 20, 1'b0, 2, 4'h3, 1'b1);
      r2 = ls_idx[1];
      bad = 0; first = -1;
      for (int i = 0; i <= r2; i++) begin
         if (rgb_log[i] !== 4'h0 || hs_log[i] !== 1'b1 || vs_log[i] !== 1'b1) begin
            bad++; if (first < 0) first = i;
         end
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL rstmid_hold: got %0d bad samples (first %0d) want 0", bad, first); end
      bad = 0; first = -1;
      for (int j = 0; j < 40; j++) begin
         if (rgb_log[r2+1+j] !== ~4'(j) || hs_log[r2+1+j] !== 1'b0 || vs_log[r2+1+j] !== 1'b1) begin
            bad++; if (first < 0) first = j;
         end
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL rstmid_resume: got %0d bad samples (first offset %0d) want 0", bad, first); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b0; ce_in = 1'b0; ce_out = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
      blank_in = 1'b0; rgb_in = 4'h0;
      @(posedge clk); #1;
      test_reset();
      test_steady();
      test_sync();
      test_overflow();
      test_early();
      test_blank();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scan_doubler.md
SCAN_DOUBLER -- requirements
Module: scan_doubler

Interface
REQ-001 Parameter LINE_MAX, default 512: line-buffer depth in pixels, power of two.
REQ-002 Parameter HS_W, default 48: output hsync pulse width in ce_out ticks.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ce_in  input  1  source pixel strobe, one clk wide, one per 6 MHz pixel.
REQ-006 ce_out  input  1  output pixel strobe, one clk wide, exactly twice the ce_in rate; a ce_out coincides with every ce_in.
REQ-007 hs_in  input  1  source horizontal sync, active-low (nHSYNC).
REQ-008 vs_in  input  1  source vertical sync, active-low (nVSYNC).
REQ-009 blank_in  input  1  source blank, active-high (VBLANK).
REQ-010 rgb_in  input  4  source colour {BLUE,GREEN,RED,RBG2}.
REQ-011 vga_hs  output  1  doubled-rate horizontal sync, active-low.
REQ-012 vga_vs  output  1  vertical sync, active-low, line-aligned.
REQ-013 vga_rgb  output  4  doubled-rate colour, 0 when blanked.

Function
REQ-014 The block SHALL detect an input line start as an hs_in 1->0 transition sampled on a clk edge where ce_in=1.
REQ-015 The block SHALL hold two LINE_MAX x 5-bit line buffers ({blank_in,rgb_in}) used ping-pong: one written, the other read.
REQ-016 On each ce_in the block SHALL write {blank_in,rgb_in} at write pointer wp into the write buffer and increment wp.
REQ-017 wp SHALL saturate at LINE_MAX-1; further pixels in that line SHALL overwrite the last entry.
REQ-018 On input line start the block SHALL latch len = pixel count of the completed line (clamped to LINE_MAX), swap buffers, clear wp to 0, clear rp to 0, and latch vs_in into vs_line.
REQ-019 On each ce_out the read pointer rp SHALL increment; when rp = len-1 it SHALL wrap to 0 and toggle the half-line flag, producing exactly two output lines per input line.
REQ-020 After the second output line completes and no new line start has arrived, rp SHALL remain at 0 and vga_rgb SHALL be 0 until the next line start.
REQ-021 A line start arriving before the second output line completes SHALL restart output line 1 immediately (truncation, no stall).
REQ-022 vga_hs SHALL be 0 for ce_out ticks with rp < HS_W on each output line, else 1; when HS_W >= len, hs is low for the whole line.
REQ-023 vga_vs SHALL equal vs_line, updated only at output line 1 start.
REQ-024 Buffer read SHALL be synchronous; vga_rgb, vga_hs, vga_vs SHALL update only on ce_out edges, with one ce_out latency from the rp value they correspond to.
REQ-025 vga_rgb SHALL be 4'b0000 when the stored blank bit is 1, else the stored rgb.
REQ-026 While len = 0 (no complete line measured since reset) outputs SHALL hold vga_rgb=0, vga_hs=1, vga_vs=1.
REQ-027 Simultaneous ce_in write and ce_out read SHALL never address the same buffer (ping-pong guarantees this).

Reset
REQ-028 With rst=1 at a clk edge the block SHALL clear wp, rp, len, vs_line, buffer select and half-line flag, and drive vga_rgb=0, vga_hs=1, vga_vs=1 on the next edge; buffer contents need not be cleared.
REQ-029 Reset asserted mid-line SHALL abandon the line; output resumes only after two subsequent line starts (one measurement).

Verification
REQ-030 Steady state: 384-pixel lines, rgb_in = pixel index[3:0], blank_in=0 -> two output lines per input line, each 384 ce_out ticks, rgb sequence 0..F repeating, one ce_out latency.
REQ-031 Sync: HS_W=48, hs_in low at line start -> vga_hs low exactly 48 ce_out ticks at start of each output line; vs_in low for 8 lines -> vga_vs low for 16 output lines.
REQ-032 Overflow: 600-pixel line, LINE_MAX=512 -> len=512, pixels 511..599 collapse to entry 511, no wp wrap.
REQ-033 Early line start: line of 384 followed by a 300-pixel line -> second output line truncated at 300-len boundary, new line 1 starts on next ce_out, no glitch beyond one tick.
REQ-034 Blank: blank_in=1, rgb_in=4'hF -> vga_rgb=0 on both output lines.
REQ-035 Reset mid-line: rst pulse at pixel 100 -> outputs 0/1/1 next edge, held until second line start, then normal doubling.
